// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG arbiter: FSM encoding, error codes, word width.
package trng_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_CHECK,
      S_DELIVER,
      S_RELEASE,
      S_HALT
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_REPEAT  = 2'b10;

endpackage

// File: rtl/trng_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set req bit at or above ptr, wrapping.
module rr_pick #(
   parameter int N     = 3,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] grant,
   output logic             any
);

   int idx;

   // Scan from the farthest offset down so the closest-to-ptr hit wins.
   always_comb begin
      grant = '0;
      any   = |req;
      idx   = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (req[PTR_W'(idx)])
            grant = PTR_W'(idx);
      end
   end

endmodule

// File: rtl/trng_arbiter.sv
// Shares one TRNG core between NUM_REQ clients with round-robin grants,
// a repetition health test on every word and a sticky error report.
module trng_arbiter
   import trng_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int TIMEOUT  = 255,
   parameter int MAX_FAIL = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] rsp_valid,
   output logic [WORD_W-1:0]  rsp_data,
   output logic               trng_request,
   input  logic               trng_ready,
   input  logic [WORD_W-1:0]  trng_word,
   output logic               busy,
   output logic               err,
   output logic [1:0]         err_code,
   input  logic               err_clr
);

   localparam int PTR_W = $clog2(NUM_REQ);
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam int FC_W  = $clog2(MAX_FAIL + 1);

   state_t            state, state_nxt;
   logic [PTR_W-1:0]  rr_ptr, grant, pick;
   logic              pick_any;
   logic [WORD_W-1:0] word_q, last_word;
   logic              last_word_vld;
   logic [FC_W-1:0]   fail_cnt, fail_inc;
   logic [TMR_W-1:0]  timer;
   logic              retry;
   logic              rep_fail, timed_out, set_to, set_rep, deliver;

   rr_pick #(.N(NUM_REQ), .PTR_W(PTR_W)) u_pick (
      .req   (req),
      .ptr   (rr_ptr),
      .grant (pick),
      .any   (pick_any)
   );

   assign rep_fail  = last_word_vld && (word_q == last_word);
   assign fail_inc  = fail_cnt + 1'b1;
   assign timed_out = (timer == TMR_W'(TIMEOUT - 1));
   assign set_to    = (state == S_FILL) && !trng_ready && timed_out;
   assign set_rep   = (state == S_CHECK) && rep_fail && (fail_inc == FC_W'(MAX_FAIL));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (pick_any) state_nxt = S_FILL;
         S_FILL:    if (trng_ready) state_nxt = S_CHECK;
                    else if (timed_out) state_nxt = S_HALT;
         S_CHECK:   if (!rep_fail) state_nxt = S_DELIVER;
                    else state_nxt = set_rep ? S_HALT : S_RELEASE;
         S_DELIVER: state_nxt = S_RELEASE;
         S_RELEASE: if (!trng_ready) state_nxt = retry ? S_FILL : S_IDLE;
         S_HALT:    if (err_clr) state_nxt = S_RELEASE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant         <= '0;
         rr_ptr        <= '0;
         word_q        <= '0;
         last_word     <= '0;
         last_word_vld <= 1'b0;
         timer         <= '0;
         retry         <= 1'b0;
      end else begin
         case (state)
            S_IDLE:    if (pick_any) grant <= pick;
            S_FILL:    if (trng_ready) word_q <= trng_word;
                       else if (!timed_out) timer <= timer + 1'b1;
            S_CHECK:   if (!rep_fail) begin
                          last_word     <= word_q;
                          last_word_vld <= 1'b1;
                       end else begin
                          retry <= !set_rep;
                       end
            S_DELIVER: rr_ptr <= (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            S_RELEASE: if (!trng_ready) begin
                          timer <= '0;
                          retry <= 1'b0;
                       end
            default: ;
         endcase
      end
   end

   // err_clr has priority so a clear is never lost to a same-cycle failure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_cnt <= '0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else if (err_clr) begin
         fail_cnt <= '0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         if (state == S_CHECK)
            fail_cnt <= rep_fail ? fail_inc : '0;
         if (set_to || set_rep) begin
            err <= 1'b1;
            if (!err) err_code <= set_to ? ERR_TIMEOUT : ERR_REPEAT;
         end
      end
   end

   assign deliver      = (state == S_DELIVER) && req[grant];
   assign rsp_valid    = deliver ? (NUM_REQ'(1) << grant) : '0;
   assign rsp_data     = deliver ? word_q : '0;
   assign trng_request = (state == S_FILL);
   assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_trng_arbiter.sv
// Scoreboard bench for trng_arbiter with a behavioural TRNG model.
module tb_trng_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [2:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        trng_request;
   logic        trng_ready;
   logic [31:0] trng_word;
   logic        busy, err, err_clr;
   logic [1:0]  err_code;

   trng_arbiter #(.NUM_REQ(3), .TIMEOUT(255), .MAX_FAIL(3)) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .trng_request (trng_request),
      .trng_ready   (trng_ready),
      .trng_word    (trng_word),
      .busy         (busy),
      .err          (err),
      .err_code     (err_code),
      .err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   // TRNG model: words come from wl[] in order; no word left means ready never rises.
   logic [31:0] wl [64];
   int wr = 0, rd = 0, cnt = 0, fill_lat = 2;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         trng_ready <= 1'b0;
         trng_word  <= '0;
         cnt        <= 0;
      end else if (!trng_request) begin
         trng_ready <= 1'b0;
         cnt        <= 0;
      end else if (!trng_ready) begin
         if (cnt >= fill_lat - 1 && rd < wr) begin
            trng_ready <= 1'b1;
            trng_word  <= wl[rd];
            rd         <= rd + 1;
         end else begin
            cnt <= cnt + 1;
         end
      end
   end

   typedef struct { int cli; logic [31:0] data; } exp_t;
   exp_t sb[$];
   int n_chk = 0, n_fail = 0, ndel = 0, fill_cyc, saved;
   bit hold = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [31:0] w);
      wl[wr] = w;
      wr++;
   endtask

   task automatic expect_rsp(input int cli, input logic [31:0] d);
      exp_t e;
      e.cli  = cli;
      e.data = d;
      sb.push_back(e);
   endtask

   // One cycle; scoreboard compare on any strobe; a non-holding client drops its req.
   task automatic cyc();
      exp_t e;
      @(negedge clk);
      if (rsp_valid != 0) begin
         ndel++;
         check("rsp_onehot", 64'($onehot(rsp_valid)), 1);
         if (sb.size() == 0) begin
            check("rsp_unexpected", rsp_valid, 0);
         end else begin
            e = sb.pop_front();
            check("rsp_client", rsp_valid, 64'(1) << e.cli);
            check("rsp_data", rsp_data, e.data);
         end
         if (!hold) req = req & ~rsp_valid;
      end
   endtask

   task automatic run_deliv(input string tag, input int n, input bit clr);
      int b = 0;
      while (ndel < n && b < 2000) begin
         cyc();
         b++;
      end
      if (clr) req = '0;
      check(tag, ndel >= n, 1);
   endtask

   task automatic wait_idle(input string tag);
      int b = 0;
      cyc();
      while (busy && b < 2000) begin
         cyc();
         b++;
      end
      check(tag, busy, 0);
   endtask

   initial begin
      rst = 1'b1; req = '0; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_trng_request", trng_request, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      check("rst_err_code", err_code, 0);
      rst = 1'b0;
      cyc();

      // All three request and hold: grants rotate 0,1,2,0.
      hold = 1;
      load(32'h1111_0000); load(32'h2222_0001); load(32'h3333_0002); load(32'h4444_0003);
      expect_rsp(0, 32'h1111_0000); expect_rsp(1, 32'h2222_0001);
      expect_rsp(2, 32'h3333_0002); expect_rsp(0, 32'h4444_0003);
      req = 3'b111;
      run_deliv("rr_four", ndel + 4, 1);
      hold = 0;
      wait_idle("rr_idle");

      // Single client with a slow TRNG.
      fill_lat = 33;
      load(32'hA5A5_0001); expect_rsp(0, 32'hA5A5_0001);
      req = 3'b001;
      run_deliv("single_deliv", ndel + 1, 0);
      wait_idle("single_idle");
      check("single_req_dropped", req, 0);
      fill_lat = 2;

      // Repeated word forces a retry that stays with client 2 while client 0 waits.
      load(32'h1234_5678); load(32'h1234_5678); load(32'h1234_5679); load(32'hCAFE_0000);
      expect_rsp(0, 32'h1234_5678); expect_rsp(2, 32'h1234_5679); expect_rsp(0, 32'hCAFE_0000);
      req = 3'b001;
      run_deliv("rep_first", ndel + 1, 0);
      wait_idle("rep_first_idle");
      req = 3'b101;
      run_deliv("rep_retry", ndel + 1, 0);
      check("rep_fail_cnt_zero", dut.fail_cnt, 0);
      run_deliv("rep_next", ndel + 1, 0);
      wait_idle("rep_idle");

      // MAX_FAIL repeats halt the block; err_clr then serves the pending request.
      load(32'hDEAD_0000); load(32'hDEAD_0000); load(32'hDEAD_0000); load(32'hDEAD_0000);
      expect_rsp(1, 32'hDEAD_0000);
      req = 3'b010;
      run_deliv("halt_first", ndel + 1, 0);
      wait_idle("halt_first_idle");
      req = 3'b010;
      for (int i = 0; i < 300 && !err; i++) cyc();
      check("halt_err", err, 1);
      check("halt_err_code", err_code, 2'b10);
      check("halt_trng_request", trng_request, 0);
      check("halt_busy", busy, 1);
      saved = ndel;
      repeat (10) cyc();
      check("halt_no_rsp", ndel, saved);
      check("halt_req_pending", req, 3'b010);
      load(32'hBEEF_0001); expect_rsp(1, 32'hBEEF_0001);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      check("clr_err", err, 0);
      check("clr_err_code", err_code, 0);
      check("clr_fail_cnt", dut.fail_cnt, 0);
      run_deliv("clr_served", ndel + 1, 0);
      wait_idle("clr_idle");

      // TRNG never ready: FILL lasts exactly TIMEOUT cycles, then HALT with timeout code.
      req = 3'b100;
      fill_cyc = 0;
      for (int i = 0; i < 400 && !err; i++) begin
         cyc();
         if (trng_request) fill_cyc++;
      end
      check("to_fill_cycles", fill_cyc, 255);
      check("to_err", err, 1);
      check("to_err_code", err_code, 2'b01);
      check("to_trng_request", trng_request, 0);
      check("to_busy", busy, 1);
      req = '0;
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      wait_idle("to_idle");
      check("to_cleared", err, 0);

      // Reset mid-FILL: request drops at once, arbitration restarts from client 0.
      fill_lat = 40;
      load(32'h600D_0006);
      req = 3'b111;
      repeat (6) cyc();
      check("mid_fill_request", trng_request, 1);
      #3 rst = 1'b1;
      #1;
      check("async_trng_request", trng_request, 0);
      check("async_busy", busy, 0);
      check("async_rsp_valid", rsp_valid, 0);
      check("async_rsp_data", rsp_data, 0);
      check("async_err", err, 0);
      @(negedge clk);
      rst = 1'b0;
      fill_lat = 2;
      expect_rsp(0, 32'h600D_0006);
      run_deliv("post_rst_deliv", ndel + 1, 1);
      wait_idle("post_rst_idle");
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/trng_arbiter.md
Name: trng_arbiter

Overview:
- Shares the single 32-bit TRNG core between NUM_REQ crypto clients (e.g. key generation, nonce/IV, masking).
- Round-robin arbitration selects one client at a time.
- Sequences the TRNG request/ready handshake for the selected client, then delivers one 32-bit word to that client only.
- Runs an online repetition health test on every word; reports timeout and health failures through a sticky error output.

Parameters:
- NUM_REQ, 3, number of requesting clients (2..8).
- TIMEOUT, 255, maximum cycles in FILL waiting for trng_ready before a timeout error.
- MAX_FAIL, 3, number of consecutive repetition failures that sets the error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_REQ  per-client level request; client holds high until its rsp_valid bit pulses.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle delivery strobe.
- rsp_data  out  32  delivered word; valid only while any rsp_valid bit is high, 0 otherwise.
- trng_request  out  1  drives the TRNG request input.
- trng_ready  in  1  TRNG ready.
- trng_word  in  32  TRNG random_number.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky health/timeout error.
- err_code  out  2  01 = timeout, 10 = repetition; first cause only.
- err_clr  in  1  synchronous clear of err, err_code and fail_cnt.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset (any time, including mid-fetch):
  - state = IDLE; rr_ptr = 0.
  - rsp_valid = 0, rsp_data = 0, trng_request = 0, busy = 0, err = 0, err_code = 0.
  - last_word_vld = 0, fail_cnt = 0, timer = 0.
- TRNG protocol:
  - The TRNG collects bits only while trng_request = 1 and trng_ready = 0.
  - trng_ready stays high until trng_request drops.
  - Dropping trng_request clears the TRNG's internal state.
- FSM states: IDLE, FILL, CHECK, DELIVER, RELEASE, HALT.
- IDLE:
  - If req is nonzero: grant = first asserted bit searching from rr_ptr upward, wrapping modulo NUM_REQ. Register grant; go to FILL.
  - Otherwise stay in IDLE.
- FILL:
  - trng_request = 1; timer increments each cycle.
  - If trng_ready = 1: capture trng_word into word_q; go to CHECK.
  - If timer reaches TIMEOUT first: err = 1, err_code = 01 (if err not already set); go to HALT.
- CHECK (1 cycle, trng_request = 0):
  - Fail condition: last_word_vld = 1 and word_q == last_word.
  - On fail:
    - fail_cnt increments.
    - If the new fail_cnt == MAX_FAIL: set err with err_code = 10; go to HALT.
    - Otherwise go to RELEASE with retry flag set.
  - On pass: fail_cnt = 0; last_word = word_q; last_word_vld = 1; go to DELIVER.
- DELIVER (1 cycle):
  - If req[grant] = 1: rsp_valid[grant] = 1 and rsp_data = word_q.
  - If req[grant] = 0 (client withdrew): word is discarded, no strobe.
  - In both cases rr_ptr = grant+1 mod NUM_REQ; go to RELEASE.
- RELEASE:
  - trng_request = 0; wait for trng_ready = 0.
  - Then timer = 0 and:
    - if retry flag set: clear it; go to FILL with the same grant;
    - otherwise go to IDLE.
  - The grant is never re-arbitrated mid-retry.
- HALT:
  - trng_request = 0; no deliveries.
  - Requests are held pending, not dropped.
  - err_clr returns the block to RELEASE, which drains trng_ready and then goes to IDLE.
- err_clr in any state clears err, err_code and fail_cnt.
- Latency: from req rising in IDLE to rsp_valid, minimum = 1 (IDLE) + TRNG fill time + 1 (CHECK) + 1 (DELIVER).
- A withdrawn req during FILL does not abort the fetch; the word is dropped at DELIVER.
- Requests arriving while busy wait for the next IDLE.
- Fairness: a continuously requesting client is served at most once every NUM_REQ grants while others are requesting.

Decomposition:
- Shared package (trng_pkg): FSM state encoding; err_code constants ERR_NONE, ERR_TIMEOUT, ERR_REPEAT; TRNG word width constant 32.
- One sub-module, rr_pick: combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant index, any flag.
- FSM, timer and health test stay in trng_arbiter.

Test Plan:
- Single client: req = 3'b001, TRNG model returns 0xA5A5_0001 after 33 cycles → rsp_valid = 001 for exactly 1 cycle with rsp_data = 0xA5A5_0001; busy returns low after trng_ready falls.
- Three clients request simultaneously, req = 3'b111, held → grants in order 0, 1, 2, 0; each rsp_valid is one-hot.
- Two consecutive identical words 0x1234_5678 → second word is not delivered; a retry is issued for the same client. If the TRNG model then returns 0x1234_5679, that word is delivered and fail_cnt = 0.
- TRNG model returns the same word 4 times (MAX_FAIL = 3) → err = 1, err_code = 10, trng_request = 0, no rsp_valid; after err_clr, a pending req is served.
- trng_ready never asserts → after 255 cycles in FILL, err = 1, err_code = 01, block in HALT.
- Assert rst during FILL → trng_request drops asynchronously; all outputs are 0; a subsequent req restarts from client 0.
